regfile_reader: RTL

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/regfile_reader.sv
// regfile_reader: captures two register-bank operands per accepted read
// request into a 2-entry FIFO. All state updates on the falling clock edge,
// the same edge on which register-bank writes commit. A write committing on
// the capture edge is bypassed into the captured operands.
module regfile_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r0,
  input  logic [7:0] r1,
  input  logic [7:0] r2,
  input  logic [7:0] r3,
  input  logic [7:0] r4,
  input  logic [7:0] r5,
  input  logic [7:0] r6,
  input  logic [7:0] r7,
  input  logic [2:0] ra,
  input  logic [2:0] rb,
  input  logic       req,
  output logic       ack,
  input  logic       wb_en,
  input  logic [2:0] wb_rs,
  input  logic [7:0] wb_data,
  output logic [7:0] opa,
  output logic [7:0] opb,
  output logic       ovalid,
  input  logic       ordy,
  output logic [7:0] rdcnt
);

  // State encoding equals the queue occupancy, so count is the state itself.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] state;
  logic [1:0] count;
  logic [7:0] head_a, head_b;
  logic [7:0] tail_a, tail_b;
  logic [7:0] cap_a, cap_b;
  logic [7:0] bank [8];
  logic       push, pop;

  assign count  = state;
  assign ack    = (count != FULL);
  assign ovalid = (count != EMPTY);
  assign push   = req && ack;
  assign pop    = ovalid && ordy;
  assign opa    = ovalid ? head_a : 8'h00;
  assign opb    = ovalid ? head_b : 8'h00;

  // Gather the bank inputs into an indexable array.
  always_comb begin
    bank[0] = r0;
    bank[1] = r1;
    bank[2] = r2;
    bank[3] = r3;
    bank[4] = r4;
    bank[5] = r5;
    bank[6] = r6;
    bank[7] = r7;
  end

  // Operand select with independent write bypass for A and B.
  always_comb begin
    // NOTE: defaults first so every path assigns cap_a/cap_b and no latch is inferred.
    cap_a = bank[ra];
    cap_b = bank[rb];
    if (wb_en && (wb_rs == ra)) cap_a = wb_data;
    if (wb_en && (wb_rs == rb)) cap_b = wb_data;
  end

  // Queue control FSM and entry storage, advancing on the falling edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the queue entries are a handful of flops, so they are reset along
      // with the state; stale data can then never appear on the operand outputs.
      state  <= EMPTY;
      head_a <= 8'h00;
      head_b <= 8'h00;
      tail_a <= 8'h00;
      tail_b <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so head<=tail reads the pre-edge tail.
      case (state)
        EMPTY: begin
          if (push) begin
            head_a <= cap_a;
            head_b <= cap_b;
            state  <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: begin
              // The only entry leaves and the new one takes its place.
              head_a <= cap_a;
              head_b <= cap_b;
            end
            2'b10: begin
              tail_a <= cap_a;
              tail_b <= cap_b;
              state  <= FULL;
            end
            2'b01: begin
              head_a <= 8'h00;
              head_b <= 8'h00;
              state  <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          // ack is low here, so only a pop can happen.
          if (pop) begin
            head_a <= tail_a;
            head_b <= tail_b;
            tail_a <= 8'h00;
            tail_b <= 8'h00;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Accepted-read counter, wrapping modulo 256.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)       rdcnt <= 8'h00;
    else if (push) rdcnt <= rdcnt + 8'd1;
  end

endmodule
